// File: rtl/hansen_fetch_unit_if.sv
// Fetch-unit bus bundle: imem request/response, EX redirect and decode output.
// The fetch unit takes the master side; memory, EX and decode take the slave side.
interface hansen_fetch_unit_if #(
  parameter int XLEN     = 32,
  parameter int FQ_DEPTH = 4
);
  logic                      imem_req_valid;
  logic                      imem_req_ready;
  logic [XLEN-1:0]           imem_req_addr;
  logic                      imem_rsp_valid;
  logic [31:0]               imem_rsp_data;
  logic                      redirect_valid;
  logic [XLEN-1:0]           redirect_pc;
  logic                      out_valid;
  logic                      out_ready;
  logic [XLEN-1:0]           out_pc;
  logic [31:0]               out_instr;
  logic [$clog2(FQ_DEPTH):0] fq_count;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output out_valid, out_pc, out_instr, fq_count,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  out_valid, out_pc, out_instr, fq_count,
    output out_ready
  );
endinterface

// File: rtl/hansen_fetch_unit.sv
// Pipelined instruction fetch: credit-limited imem requests, pc tag FIFO,
// prefetch queue toward decode, redirect flush with stale-response dropping.
module hansen_fetch_unit #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int              FQ_DEPTH        = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input logic clk,
  input logic reset,
  hansen_fetch_unit_if.master bus
);
  localparam int IW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] MAXO = 32'(MAX_OUTSTANDING);
  localparam logic [31:0] FQD  = 32'(FQ_DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [IW-1:0]   inflight_q, inflight_d;
  logic [IW-1:0]   drop_q, drop_d;
  logic [TW-1:0]   tag_wr_q, tag_rd_q;
  logic [XLEN-1:0] tag_q [MAX_OUTSTANDING];
  logic [PW-1:0]   fq_wr_q, fq_rd_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] fq_pc_q [FQ_DEPTH];
  logic [31:0]     fq_ins_q [FQ_DEPTH];

  logic [31:0] live;
  logic        req_v, issue, rsp_ok, push, pop, out_v;

  always_comb begin
    live  = 32'(inflight_q) - 32'(drop_q);
    req_v = !reset && !bus.redirect_valid &&
            (32'(inflight_q) < MAXO) &&
            (live + 32'(cnt_q) < FQD);
    issue  = req_v && bus.imem_req_ready;
    rsp_ok = bus.imem_rsp_valid && (inflight_q != '0);
    push   = rsp_ok && (drop_q == '0) && !bus.redirect_valid;
    pop    = (cnt_q != '0) && bus.out_ready && !bus.redirect_valid;

    inflight_d = inflight_q;
    if (issue)  inflight_d = inflight_d + IW'(1);
    if (rsp_ok) inflight_d = inflight_d - IW'(1);

    drop_d = drop_q;
    if (rsp_ok && (drop_q != '0)) drop_d = drop_q - IW'(1);
    // every survivor of a redirect belongs to the old path
    if (bus.redirect_valid) drop_d = inflight_d;

    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_valid)
      fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
    else if (issue)
      fetch_pc_d = fetch_pc_q + XLEN'(4);

    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (bus.redirect_valid) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      fq_wr_q    <= '0;
      fq_rd_q    <= '0;
      cnt_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      if (issue)
        tag_wr_q <= (tag_wr_q == TW'(MAX_OUTSTANDING - 1)) ?
                    '0 : tag_wr_q + TW'(1);
      if (rsp_ok)
        tag_rd_q <= (tag_rd_q == TW'(MAX_OUTSTANDING - 1)) ?
                    '0 : tag_rd_q + TW'(1);
      if (bus.redirect_valid) begin
        fq_wr_q <= '0;
        fq_rd_q <= '0;
      end else begin
        if (push) fq_wr_q <= fq_wr_q + PW'(1);
        if (pop)  fq_rd_q <= fq_rd_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) tag_q[tag_wr_q] <= fetch_pc_q;
    if (push) begin
      fq_pc_q[fq_wr_q]  <= tag_q[tag_rd_q];
      fq_ins_q[fq_wr_q] <= bus.imem_rsp_data;
    end
  end

  assign out_v              = !reset && (cnt_q != '0);
  assign bus.imem_req_valid = req_v;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.out_valid      = out_v;
  assign bus.out_pc         = out_v ? fq_pc_q[fq_rd_q] : '0;
  assign bus.out_instr      = out_v ? fq_ins_q[fq_rd_q] : '0;
  assign bus.fq_count       = reset ? '0 : cnt_q;

  assert property (@(posedge clk) disable iff (reset)
    (drop_q <= inflight_q) && (32'(inflight_q) <= MAXO) &&
    (32'(cnt_q) <= FQD) && (live + 32'(cnt_q) <= FQD));
endmodule
